// File: rtl/matrix_add_pkg.sv
// matrix_add_pkg: shared states, element count and element-index encoding
package matrix_add_pkg;
  localparam int NUM_ELEM = 4;
  localparam int IDX_W = 2;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE, S_DONE} state_t;
  typedef enum logic [IDX_W-1:0] {E11 = 2'd0, E12 = 2'd1, E21 = 2'd2, E22 = 2'd3} elem_t;
endpackage

// File: rtl/seq_timeout_counter.sv
// seq_timeout_counter: counts wait cycles and flags when the limit is reached
module seq_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);
  logic [7:0] cnt_q, cnt_d;
  // clear wins over enable so every issue starts a fresh wait window
  always_comb cnt_d = clear ? 8'd0 : enable ? cnt_q + 8'd1 : cnt_q;
  // count register
  always_ff @(posedge clk)
    if (rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign hit = cnt_q == 8'(TIMEOUT);
endmodule

// File: rtl/matrix_add_sequencer.sv
// matrix_add_sequencer: adds two 2x2 matrices through one shared external adder
module matrix_add_sequencer
  import matrix_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             input_Clk,
  input  logic             input_Reset,
  input  logic             input_Start,
  input  logic [WIDTH-1:0] input_A11,
  input  logic [WIDTH-1:0] input_A12,
  input  logic [WIDTH-1:0] input_A21,
  input  logic [WIDTH-1:0] input_A22,
  input  logic [WIDTH-1:0] input_B11,
  input  logic [WIDTH-1:0] input_B12,
  input  logic [WIDTH-1:0] input_B21,
  input  logic [WIDTH-1:0] input_B22,
  input  logic             input_C_Ack,
  output logic [WIDTH-1:0] output_C11,
  output logic [WIDTH-1:0] output_C12,
  output logic [WIDTH-1:0] output_C21,
  output logic [WIDTH-1:0] output_C22,
  output logic             output_Stable,
  output logic             output_Busy,
  output logic             output_Error,
  output logic [WIDTH-1:0] output_Add_N1,
  output logic [WIDTH-1:0] output_Add_N2,
  output logic             output_Add_Load,
  output logic             output_Add_Ack,
  input  logic             input_Add_Ready,
  input  logic [WIDTH-1:0] input_Add_Result
);
  typedef logic [WIDTH-1:0] word_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  word_t a_q [NUM_ELEM];
  word_t a_d [NUM_ELEM];
  word_t b_q [NUM_ELEM];
  word_t b_d [NUM_ELEM];
  word_t c_q [NUM_ELEM];
  word_t c_d [NUM_ELEM];
  logic err_q, err_d, stable_q, stable_d, load_q, load_d, ack_q, ack_d, hit;
  seq_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (input_Clk),
    .rst   (input_Reset),
    .clear (state_q == S_ISSUE),
    .enable(state_q == S_WAIT && !input_Add_Ready && !hit),
    .hit   (hit)
  );
  // next state, operand/result capture and registered strobes
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (input_Start) begin
        a_d = '{input_A11, input_A12, input_A21, input_A22};
        b_d = '{input_B11, input_B12, input_B21, input_B22};
        c_d = '{default: '0};
        err_d = 1'b0;
        idx_d = E11;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: if (input_Add_Ready) begin
        c_d[idx_q] = input_Add_Result;
        state_d = S_RELEASE;
      end else if (hit) begin
        err_d = 1'b1;
        state_d = S_DONE;
      end
      S_RELEASE: if (!input_Add_Ready) begin
        state_d = idx_q == E22 ? S_DONE : S_ISSUE;
        idx_d = idx_q == E22 ? idx_q : idx_q + IDX_W'(1);
      end
      S_DONE: if (input_C_Ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    load_d = state_d == S_ISSUE;
    ack_d = state_q == S_WAIT && input_Add_Ready;
    stable_d = state_d == S_DONE;
  end
  // state and datapath registers; reset overrides everything
  always_ff @(posedge input_Clk)
    if (input_Reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      c_q <= '{default: '0};
      err_q <= 1'b0;
      stable_q <= 1'b0;
      load_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      err_q <= err_d;
      stable_q <= stable_d;
      load_q <= load_d;
      ack_q <= ack_d;
    end
  assign output_C11 = c_q[E11];
  assign output_C12 = c_q[E12];
  assign output_C21 = c_q[E21];
  assign output_C22 = c_q[E22];
  assign output_Stable = stable_q;
  assign output_Busy = state_q != S_IDLE;
  assign output_Error = err_q;
  assign output_Add_N1 = a_q[idx_q];
  assign output_Add_N2 = b_q[idx_q];
  assign output_Add_Load = load_q;
  assign output_Add_Ack = ack_q;
endmodule

// File: tb/tb_matrix_add_sequencer.sv
// tb_matrix_add_sequencer: directed scenarios against a latency-3 adder model
module tb_matrix_add_sequencer;
  localparam int L = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, c_ack = 1'b0;
  logic [31:0] a11 = 0, a12 = 0, a21 = 0, a22 = 0, b11 = 0, b12 = 0, b21 = 0, b22 = 0;
  logic [31:0] c11, c12, c21, c22, n1, n2, res = 0;
  logic stable, busy, err, load, ack, ready = 1'b0;
  int cmp = 0, bad = 0, loads = 0, acks = 0, viol = 0, cd = 0, hcnt = 0, hold = 0;
  bit never = 1'b0;

  matrix_add_sequencer #(.WIDTH(32), .TIMEOUT(5)) dut (
    .input_Clk(clk), .input_Reset(rst), .input_Start(start),
    .input_A11(a11), .input_A12(a12), .input_A21(a21), .input_A22(a22),
    .input_B11(b11), .input_B12(b12), .input_B21(b21), .input_B22(b22),
    .input_C_Ack(c_ack),
    .output_C11(c11), .output_C12(c12), .output_C21(c21), .output_C22(c22),
    .output_Stable(stable), .output_Busy(busy), .output_Error(err),
    .output_Add_N1(n1), .output_Add_N2(n2), .output_Add_Load(load), .output_Add_Ack(ack),
    .input_Add_Ready(ready), .input_Add_Result(res)
  );

  always #5 clk = ~clk;

  // adder model: ready rises L cycles after load, falls one cycle (plus hold) after ack
  always @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0; cd <= 0; hcnt <= 0;
    end else begin
      if (load && !never) begin cd <= L - 1; res <= n1 + n2; end
      else if (cd != 0) begin if (cd == 1) ready <= 1'b1; cd <= cd - 1; end
      if (ack) begin if (hold == 0) ready <= 1'b0; else hcnt <= hold; end
      else if (hcnt != 0) begin if (hcnt == 1) ready <= 1'b0; hcnt <= hcnt - 1; end
    end
  end

  always @(posedge clk) begin
    if (load) loads <= loads + 1;
    if (ack) acks <= acks + 1;
    if (load && ready) viol <= viol + 1;
  end

  task automatic set_ops(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
    {a11, a12, a21, a22} = {a0, a1, a2, a3};
    {b11, b12, b21, b22} = {b0, b1, b2, b3};
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_stable(output int lat);
    lat = 1;
    while (!stable && lat < 200) begin @(negedge clk); lat++; end
    cmp++;
    if (!stable) begin bad++; $display("FAIL wait_stable: stable=%b after %0d cycles, required 1", stable, lat); end
  endtask

  task automatic pulse_ack();
    @(negedge clk); c_ack = 1'b1;
    @(negedge clk); c_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cmp++;
    if ({busy, stable, err, load, ack} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: busy/stable/err/load/ack=%b required 00000", {busy, stable, err, load, ack});
    end
    cmp++;
    if ({c11, c12, c21, c22} !== 128'd0) begin
      bad++; $display("FAIL reset_c: C=%0d,%0d,%0d,%0d required 0,0,0,0", c11, c12, c21, c22);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, l0, k0;
    l0 = loads; k0 = acks;
    set_ops(1, 2, 3, 4, 10, 20, 30, 40);
    pulse_start();
    wait_stable(lat);
    cmp++;
    if (lat !== 25) begin bad++; $display("FAIL basic_latency: got %0d required 25", lat); end
    cmp++;
    if (loads - l0 !== 4 || acks - k0 !== 4) begin
      bad++; $display("FAIL basic_pulses: loads=%0d acks=%0d required 4/4", loads - l0, acks - k0);
    end
    cmp++;
    if ({c11, c12, c21, c22} !== {32'd11, 32'd22, 32'd33, 32'd44}) begin
      bad++; $display("FAIL basic_c: C=%0d,%0d,%0d,%0d required 11,22,33,44", c11, c12, c21, c22);
    end
    cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_flags: err=%b busy=%b required 0/1", err, busy); end
    pulse_ack();
    cmp++;
    if (stable !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_release: stable=%b busy=%b required 0/0", stable, busy); end
  endtask

  task automatic test_ack_delay();
    int lat;
    set_ops(5, 6, 7, 8, 100, 200, 300, 400);
    pulse_start();
    wait_stable(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmp++;
      if (stable !== 1'b1 || {c11, c12, c21, c22} !== {32'd105, 32'd206, 32'd307, 32'd408}) begin
        bad++; $display("FAIL ack_delay_hold[%0d]: stable=%b C=%0d,%0d,%0d,%0d required 1 105,206,307,408", i, stable, c11, c12, c21, c22);
      end
    end
    pulse_ack();
    cmp++;
    if (stable !== 1'b0) begin bad++; $display("FAIL ack_delay_fall: stable=%b required 0", stable); end
    repeat (3) @(negedge clk);
    cmp++;
    if ({c11, c22} !== {32'd105, 32'd408}) begin bad++; $display("FAIL idle_hold_c: C11=%0d C22=%0d required 105/408", c11, c22); end
  endtask

  task automatic test_timeout();
    int lat, l0;
    never = 1'b1;
    l0 = loads;
    set_ops(7, 7, 7, 7, 1, 1, 1, 1);
    pulse_start();
    wait_stable(lat);
    cmp++;
    if (lat !== 8) begin bad++; $display("FAIL timeout_latency: got %0d required 8", lat); end
    cmp++;
    if (err !== 1'b1 || c11 !== 32'd0) begin bad++; $display("FAIL timeout_err: err=%b C11=%0d required 1/0", err, c11); end
    repeat (6) @(negedge clk);
    cmp++;
    if (loads - l0 !== 1 || stable !== 1'b1) begin
      bad++; $display("FAIL timeout_no_reload: loads=%0d stable=%b required 1/1", loads - l0, stable);
    end
    pulse_ack();
    never = 1'b0;
    cmp++;
    if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL timeout_err_sticky: err=%b busy=%b required 1/0", err, busy); end
  endtask

  task automatic test_start_ignored();
    int lat, l0;
    l0 = loads;
    set_ops(1, 1, 1, 1, 2, 2, 2, 2);
    pulse_start();
    @(negedge clk);
    cmp++;
    if (err !== 1'b0) begin bad++; $display("FAIL start_clears_err: err=%b required 0", err); end
    set_ops(9, 9, 9, 9, 9, 9, 9, 9);
    start = 1'b1; c_ack = 1'b1;
    @(negedge clk); start = 1'b0; c_ack = 1'b0;
    wait_stable(lat);
    cmp++;
    if ({c11, c12, c21, c22} !== {32'd3, 32'd3, 32'd3, 32'd3} || loads - l0 !== 4) begin
      bad++; $display("FAIL start_in_wait: C=%0d,%0d,%0d,%0d loads=%0d required 3,3,3,3 loads 4", c11, c12, c21, c22, loads - l0);
    end
    @(negedge clk); start = 1'b1; c_ack = 1'b1;
    @(negedge clk); start = 1'b0; c_ack = 1'b0;
    repeat (3) begin
      cmp++;
      if (busy !== 1'b0 || stable !== 1'b0 || load !== 1'b0) begin
        bad++; $display("FAIL start_with_ack: busy=%b stable=%b load=%b required 0/0/0", busy, stable, load);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int lat, l0, n;
    l0 = loads;
    set_ops(1, 2, 3, 4, 1, 2, 3, 4);
    pulse_start();
    n = 0;
    while (loads - l0 < 3 && n < 100) begin @(negedge clk); n++; end
    cmp++;
    if (loads - l0 !== 3) begin bad++; $display("FAIL reset_mid_reach: loads=%0d required 3", loads - l0); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cmp++;
    if ({busy, stable, err, load, ack} !== 5'b0 || {c11, c12, n1, n2} !== 128'd0) begin
      bad++; $display("FAIL reset_mid_outputs: flags=%b C11=%0d C12=%0d N1=%0d N2=%0d required all 0", {busy, stable, err, load, ack}, c11, c12, n1, n2);
    end
    set_ops(2, 4, 6, 8, 1, 1, 1, 1);
    pulse_start();
    wait_stable(lat);
    cmp++;
    if (lat !== 25 || {c11, c12, c21, c22} !== {32'd3, 32'd5, 32'd7, 32'd9}) begin
      bad++; $display("FAIL reset_mid_restart: lat=%0d C=%0d,%0d,%0d,%0d required 25 3,5,7,9", lat, c11, c12, c21, c22);
    end
    pulse_ack();
  endtask

  task automatic test_hold_ready();
    int lat, l0, v0;
    hold = 4;
    l0 = loads; v0 = viol;
    set_ops(100, 200, 300, 400, 1, 2, 3, 4);
    pulse_start();
    wait_stable(lat);
    cmp++;
    if (lat !== 41) begin bad++; $display("FAIL hold_latency: got %0d required 41", lat); end
    cmp++;
    if (viol - v0 !== 0 || loads - l0 !== 4) begin
      bad++; $display("FAIL hold_load_order: loads_with_ready=%0d loads=%0d required 0/4", viol - v0, loads - l0);
    end
    cmp++;
    if ({c11, c12, c21, c22} !== {32'd101, 32'd202, 32'd303, 32'd404}) begin
      bad++; $display("FAIL hold_c: C=%0d,%0d,%0d,%0d required 101,202,303,404", c11, c12, c21, c22);
    end
    pulse_ack();
    hold = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_hold_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/matrix_add_sequencer.md
MATRIX_ADD_SEQUENCER -- requirements
Module: matrix_add_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for adder ready (range 1..255).
REQ-003 SHALL have port input_Clk, in, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port input_Reset, in, 1, synchronous active-high reset.
REQ-005 SHALL have port input_Start, in, 1, a request to add the two 2x2 matrices.
REQ-006 SHALL have ports input_A11, input_A12, input_A21, input_A22, in, WIDTH each, matrix A elements.
REQ-007 SHALL have ports input_B11, input_B12, input_B21, input_B22, in, WIDTH each, matrix B elements.
REQ-008 SHALL have port input_C_Ack, in, 1, which the consumer asserts once it has read the result.
REQ-009 SHALL have ports output_C11, output_C12, output_C21, output_C22, out, WIDTH each, registered result elements.
REQ-010 SHALL have port output_Stable, out, 1, which is high while the results are valid.
REQ-011 SHALL have port output_Busy, out, 1, which is high whenever the state is not IDLE.
REQ-012 SHALL have port output_Error, out, 1, which indicates that an adder timeout aborted the current operation.
REQ-013 SHALL have ports output_Add_N1 and output_Add_N2, out, WIDTH each, operands to the shared adder.
REQ-014 SHALL have port output_Add_Load, out, 1, a one-cycle load pulse to the shared adder.
REQ-015 SHALL have port output_Add_Ack, out, 1, a one-cycle result-acknowledge pulse to the shared adder.
REQ-016 SHALL have port input_Add_Ready, in, 1, the shared adder's result_ready.
REQ-017 SHALL have port input_Add_Result, in, WIDTH, the shared adder's result.

Function
REQ-018 SHALL time-multiplex one adder over the four elements in index order 0=11, 1=12, 2=21, 3=22.
REQ-019 SHALL implement the states IDLE, ISSUE, WAIT, RELEASE and DONE.
REQ-020 In IDLE with input_Start=1, the block SHALL register all eight operands, clear the C registers and output_Error, set index to 0, and go to ISSUE.
REQ-021 In ISSUE, the block SHALL drive output_Add_N1/N2 from the registered A[index]/B[index], assert output_Add_Load for exactly this cycle, clear the timer, and go to WAIT.
REQ-022 output_Add_N1/N2 SHALL hold the current-index operands from ISSUE through RELEASE.
REQ-023 In WAIT with input_Add_Ready=1, the block SHALL capture input_Add_Result into C[index], assert output_Add_Ack for exactly this cycle, and go to RELEASE.
REQ-024 In WAIT with input_Add_Ready=0, the timer SHALL increment by one per cycle; when the timer equals TIMEOUT, the block SHALL set output_Error and go to DONE, leaving unfinished C elements at 0.
REQ-025 In RELEASE, the block SHALL wait for input_Add_Ready=0; then it SHALL go to DONE if index=3, otherwise increment index and go to ISSUE.
REQ-026 In DONE, output_Stable SHALL be 1; on input_C_Ack=1 the block SHALL go to IDLE, with output_Stable falling on the next edge.
REQ-027 C outputs SHALL hold their values after DONE until the next accepted input_Start.
REQ-028 input_Start SHALL be ignored outside IDLE, including when asserted in the same cycle as input_C_Ack in DONE.
REQ-029 input_C_Ack SHALL be ignored outside DONE.
REQ-030 With an adder whose ready rises L cycles after load and falls 1 cycle after ack, Start-to-Stable latency SHALL be 1+4*(L+3) cycles.
REQ-031 output_Error SHALL stay set until the next accepted input_Start or reset.

Reset
REQ-032 Reset SHALL set the state to IDLE, index and timer to 0, all C outputs to 0, and output_Stable, output_Busy, output_Error, output_Add_Load and output_Add_Ack to 0.
REQ-033 Reset SHALL take priority over all other inputs, including when asserted mid-operation; no load or ack pulse SHALL be issued in the reset cycle.

Structure
REQ-034 Package matrix_add_pkg SHALL hold the state enum, the NUM_ELEM=4 constant and the element-index encoding.
REQ-035 The timeout counter SHALL be the one sub-module, seq_timeout_counter, with clear/enable inputs and a hit output.
REQ-036 The adder itself SHALL be external and SHALL NOT be instantiated inside this block.

Verification (bench adder model: Result=N1+N2 integer, L=3)
REQ-037 A=1,2,3,4 and B=10,20,30,40, Start pulse -> exactly four load and four ack pulses, C=11,22,33,44, Stable high at cycle 25.
REQ-038 Consumer delays input_C_Ack 10 cycles -> Stable and C held for the whole delay; Stable low one cycle after Ack.
REQ-039 Model never raises ready, TIMEOUT=5 -> Error=1 and Stable=1 after 6 WAIT cycles, C11=0, no further loads.
REQ-040 Start pulsed during WAIT, and Start together with Ack in DONE -> both ignored; the next operation requires a fresh Start in IDLE.
REQ-041 Reset asserted in WAIT of element 2 -> next cycle all outputs are at reset values, and a new Start completes normally.
REQ-042 Model holds ready high 4 cycles after ack -> controller stays in RELEASE and the next load occurs only after ready falls.
